inertial_imu_reader: RTL

- Producer side of the inertial data path. Initializes the 6-axis IMU over a 4-wire SPI link (this block is the SPI master).
- On each data-ready interrupt, reads raw pitch rate and Z acceleration and presents them with a one-cycle vld strobe.
- Outputs feed the pitch integrator directly: vld, ptch_rt, AZ.

---
 rtl/inertial_imu_reader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/inertial_imu_reader.sv
// IMU front end: configures a 6-axis IMU over 4-wire SPI (mode 3 master), then on each
// data-ready interrupt reads pitch rate and Z acceleration and presents them with a vld strobe.
module inertial_imu_reader #(
    parameter int INIT_WAIT  = 65536,
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    localparam int IW = $clog2(INIT_WAIT + 1);

    // Divider landmarks: loading 3/4 of full scale yields a quarter-period front porch
    // with SCLK high; the frame ends a quarter period after the 16th rising edge.
    localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = {2'b11, {(SCLK_DIV_W-2){1'b0}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL = {SCLK_DIV_W{1'b1}};
    localparam logic [SCLK_DIV_W-1:0] DIV_END  = {2'b10, {(SCLK_DIV_W-2){1'b1}}};

    localparam logic [3:0] INIT_DLY = 4'd0;
    localparam logic [3:0] INIT1    = 4'd1;
    localparam logic [3:0] INIT2    = 4'd2;
    localparam logic [3:0] INIT3    = 4'd3;
    localparam logic [3:0] INIT4    = 4'd4;
    localparam logic [3:0] WAIT_INT = 4'd5;
    localparam logic [3:0] RD_PL    = 4'd6;
    localparam logic [3:0] RD_PH    = 4'd7;
    localparam logic [3:0] RD_AL    = 4'd8;
    localparam logic [3:0] RD_AH    = 4'd9;
    localparam logic [3:0] DONE     = 4'd10;

    logic [3:0]            state;
    logic [IW-1:0]         init_cnt;
    logic                  int_ff1, int_ff2, int_ff3;
    logic                  trig;
    logic                  pending;
    logic                  launched;
    logic                  ss_gap;
    logic [SCLK_DIV_W-1:0] div;
    logic [4:0]            rise_cnt;
    logic [15:0]           tx;
    logic [7:0]            rx;
    logic [7:0]            pl, ph, al;
    logic [15:0]           frame_word;
    logic                  issue;
    logic                  start;
    logic                  done_now;

    // INT is asynchronous: two flops to synchronize, a third to find the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
            int_ff3 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            int_ff3 <= int_ff2;
        end
    end

    assign trig = int_ff2 & ~int_ff3;

    always_comb begin
        frame_word = 16'h0000;
        case (state)
            INIT1:   frame_word = 16'h0D02;
            INIT2:   frame_word = 16'h1053;
            INIT3:   frame_word = 16'h1150;
            INIT4:   frame_word = 16'h1460;
            RD_PL:   frame_word = 16'hA200;
            RD_PH:   frame_word = 16'hA300;
            RD_AL:   frame_word = 16'hAC00;
            RD_AH:   frame_word = 16'hAD00;
            default: frame_word = 16'h0000;
        endcase
    end

    assign issue    = state inside {INIT1, INIT2, INIT3, INIT4, RD_PL, RD_PH, RD_AL, RD_AH};
    // ss_gap is SS_n delayed one clk, guaranteeing two idle clks between frames.
    assign start    = issue && !launched && SS_n && ss_gap;
    assign done_now = !SS_n && (rise_cnt == 5'd16) && (div == DIV_END);
    assign SCLK     = SS_n | div[SCLK_DIV_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n     <= 1'b1;
            ss_gap   <= 1'b0;
            MOSI     <= 1'b0;
            div      <= '0;
            rise_cnt <= '0;
            tx       <= '0;
            rx       <= '0;
        end else begin
            ss_gap <= SS_n;
            if (start) begin
                SS_n     <= 1'b0;
                div      <= DIV_LOAD;
                rise_cnt <= '0;
                tx       <= frame_word;
                rx       <= '0;
                MOSI     <= 1'b0;
            end else if (!SS_n) begin
                div <= div + 1'b1;
                if (div == DIV_FALL) begin
                    MOSI <= tx[15];
                    tx   <= {tx[14:0], 1'b0};
                end
                if (div == DIV_RISE) begin
                    rx       <= {rx[6:0], MISO};
                    rise_cnt <= rise_cnt + 5'd1;
                end
                if (done_now) begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                end
            end
        end
    end

    // vld is a single-cycle strobe with no backpressure: ptch_rt/AZ are valid and
    // newly loaded exactly on the cycle vld is high, and hold until the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT_DLY;
            init_cnt <= '0;
            pending  <= 1'b0;
            launched <= 1'b0;
            pl       <= '0;
            ph       <= '0;
            al       <= '0;
            ptch_rt  <= '0;
            AZ       <= '0;
            vld      <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (start)
                launched <= 1'b1;
            else if (done_now)
                launched <= 1'b0;
            case (state)
                INIT_DLY: begin
                    if (init_cnt == IW'(INIT_WAIT - 1))
                        state <= INIT1;
                    else
                        init_cnt <= init_cnt + 1'b1;
                end
                INIT1, INIT2, INIT3: begin
                    if (done_now)
                        state <= state + 4'd1;
                end
                INIT4: begin
                    if (done_now) begin
                        state   <= WAIT_INT;
                        pending <= 1'b0;
                    end
                end
                WAIT_INT: begin
                    if (trig || pending) begin
                        state   <= RD_PL;
                        pending <= 1'b0;
                    end
                end
                RD_PL: begin
                    if (trig) pending <= 1'b1;
                    if (done_now) begin
                        pl    <= rx;
                        state <= RD_PH;
                    end
                end
                RD_PH: begin
                    if (trig) pending <= 1'b1;
                    if (done_now) begin
                        ph    <= rx;
                        state <= RD_AL;
                    end
                end
                RD_AL: begin
                    if (trig) pending <= 1'b1;
                    if (done_now) begin
                        al    <= rx;
                        state <= RD_AH;
                    end
                end
                RD_AH: begin
                    if (trig) pending <= 1'b1;
                    if (done_now) begin
                        ptch_rt <= {ph, pl};
                        AZ      <= {rx, al};
                        vld     <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (trig) pending <= 1'b1;
                    state <= WAIT_INT;
                end
                default: state <= INIT_DLY;
            endcase
        end
    end

endmodule
